// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the VGA timing generator and its pixel source / DAC.
// The master side is the timing generator; the slave side is the pixel source plus monitor.
interface vga_timing_gen_if #(
  parameter int CW    = 8,
  parameter int CNT_W = 11
);
  logic             pix_en;
  logic [CW-1:0]    red_in;
  logic [CW-1:0]    green_in;
  logic [CW-1:0]    blue_in;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             req_active;
  logic             line_start;
  logic             frame_start;
  logic             hsync;
  logic             vsync;
  logic             vga_blank;
  logic [CW-1:0]    vga_red;
  logic [CW-1:0]    vga_green;
  logic [CW-1:0]    vga_blue;
  logic             vga_sync;
  logic             vga_clk;

  modport master (
    input  pix_en, red_in, green_in, blue_in,
    output x, y, req_active, line_start, frame_start,
           hsync, vsync, vga_blank, vga_red, vga_green, vga_blue,
           vga_sync, vga_clk
  );

  modport slave (
    output pix_en, red_in, green_in, blue_in,
    input  x, y, req_active, line_start, frame_start,
           hsync, vsync, vga_blank, vga_red, vga_green, vga_blue,
           vga_sync, vga_clk
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: requests pixels LOOKAHEAD enabled cycles ahead
// and emits registered sync/blank/colour aligned to the returned pixel data.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_PULSE   = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_PULSE   = 2,
  parameter int V_BACK    = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CW        = 8,
  parameter int CNT_W     = 11,
  parameter int LOOKAHEAD = 1
) (
  input logic              clk,
  input logic              reset,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_A_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_FP_END = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SP_END = CNT_W'(H_ACTIVE + H_FRONT + H_PULSE);
  localparam logic [CNT_W-1:0] V_A_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_FP_END = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SP_END = CNT_W'(V_ACTIVE + V_FRONT + V_PULSE);

  if (H_ACTIVE < 1 || H_FRONT < 1 || H_PULSE < 1 || H_BACK < 1) begin : g_bad_h
    $error("vga_timing_gen: every horizontal region length must be >= 1");
  end
  if (V_ACTIVE < 1 || V_FRONT < 1 || V_PULSE < 1 || V_BACK < 1) begin : g_bad_v
    $error("vga_timing_gen: every vertical region length must be >= 1");
  end
  if (CNT_W < 1 || CNT_W > 30 || (H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W))
  begin : g_bad_w
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL-1 or V_TOTAL-1");
  end
  if (LOOKAHEAD < 0 || LOOKAHEAD > 4) begin : g_bad_la
    $error("vga_timing_gen: LOOKAHEAD must be in 0..4");
  end

  typedef enum logic [1:0] {
    REG_ACTIVE,
    REG_FRONT,
    REG_PULSE,
    REG_BACK
  } region_e;

  function automatic region_e decode(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] a_end,
                                     input logic [CNT_W-1:0] fp_end,
                                     input logic [CNT_W-1:0] sp_end);
    if (cnt < a_end)       return REG_ACTIVE;
    else if (cnt < fp_end) return REG_FRONT;
    else if (cnt < sp_end) return REG_PULSE;
    else                   return REG_BACK;
  endfunction

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  region_e          h_reg;
  region_e          v_reg;
  logic             req_active;
  logic             hs_now;
  logic             vs_now;

  logic [LOOKAHEAD:0] hs_dl;
  logic [LOOKAHEAD:0] vs_dl;
  logic [LOOKAHEAD:0] act_dl;
  logic               act_tap;

  logic [CW-1:0] red_q;
  logic [CW-1:0] green_q;
  logic [CW-1:0] blue_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (bus.pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + ONE;
      end else begin
        h_cnt <= h_cnt + ONE;
      end
    end
  end

  always_comb begin
    h_reg      = decode(h_cnt, H_A_END, H_FP_END, H_SP_END);
    v_reg      = decode(v_cnt, V_A_END, V_FP_END, V_SP_END);
    req_active = (h_reg == REG_ACTIVE) && (v_reg == REG_ACTIVE);
    hs_now     = (h_reg == REG_PULSE);
    vs_now     = (v_reg == REG_PULSE);
  end

  assign bus.req_active  = req_active;
  assign bus.x           = req_active ? h_cnt : '0;
  assign bus.y           = req_active ? v_cnt : '0;
  assign bus.line_start  = bus.pix_en && (h_cnt == '0) && (v_reg == REG_ACTIVE);
  assign bus.frame_start = bus.pix_en && (h_cnt == '0) && (v_cnt == '0);

  // Flags are stored as "asserted"; polarity is applied only at the pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_dl  <= '0;
      vs_dl  <= '0;
      act_dl <= '0;
    end else if (bus.pix_en) begin
      hs_dl[0]  <= hs_now;
      vs_dl[0]  <= vs_now;
      act_dl[0] <= req_active;
      for (int unsigned i = 1; i <= LOOKAHEAD; i++) begin
        hs_dl[i]  <= hs_dl[i-1];
        vs_dl[i]  <= vs_dl[i-1];
        act_dl[i] <= act_dl[i-1];
      end
    end
  end

  // Active flag delayed by exactly LOOKAHEAD, matching when the pixel data arrives.
  if (LOOKAHEAD == 0) begin : g_tap_now
    assign act_tap = req_active;
  end else begin : g_tap_dl
    assign act_tap = act_dl[LOOKAHEAD-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else if (bus.pix_en) begin
      red_q   <= act_tap ? bus.red_in   : '0;
      green_q <= act_tap ? bus.green_in : '0;
      blue_q  <= act_tap ? bus.blue_in  : '0;
    end
  end

  assign bus.hsync     = HS_POL ? hs_dl[LOOKAHEAD] : ~hs_dl[LOOKAHEAD];
  assign bus.vsync     = VS_POL ? vs_dl[LOOKAHEAD] : ~vs_dl[LOOKAHEAD];
  assign bus.vga_blank = act_dl[LOOKAHEAD];
  assign bus.vga_red   = red_q;
  assign bus.vga_green = green_q;
  assign bus.vga_blue  = blue_q;
  assign bus.vga_sync  = 1'b0;
  assign bus.vga_clk   = clk;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen
Interface
REQ-001 Parameters SHALL be H_ACTIVE/H_FRONT/H_PULSE/H_BACK, default 640/16/96/48, horizontal region lengths in pixel clocks, each >=1.
REQ-002 Parameters SHALL be V_ACTIVE/V_FRONT/V_PULSE/V_BACK, default 480/10/2/33, vertical region lengths in lines, each >=1.
REQ-003 Parameter HS_POL/VS_POL SHALL be 0/0, sync asserted level (0 = active-low).
REQ-004 Parameter CW SHALL be 8, colour channel width.
REQ-005 Parameter CNT_W SHALL be 11, x/y and counter width; elaboration error if H_TOTAL-1 or V_TOTAL-1 does not fit.
REQ-006 Parameter LOOKAHEAD SHALL be 1, pixel-source latency in enabled cycles; legal range 0..4, elaboration error otherwise.
REQ-007 clk  in  1  single clock, all logic on its rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 pix_en  in  1  pixel clock enable; 0 freezes all state.
REQ-010 red_in/green_in/blue_in  in  CW each  colour for the pixel requested LOOKAHEAD enabled cycles earlier.
REQ-011 x, y  out  CNT_W each  requested pixel coordinate; 0 when req_active=0.
REQ-012 req_active  out  1  current counter position lies in the active area.
REQ-013 line_start  out  1  one-enabled-cycle pulse at h_cnt=0 of every active line.
REQ-014 frame_start  out  1  one-enabled-cycle pulse at h_cnt=0, v_cnt=0.
REQ-015 hsync, vsync  out  1 each  registered syncs at HS_POL/VS_POL when asserted.
REQ-016 vga_blank  out  1  registered, 1 = active video, 0 = blanking.
REQ-017 vga_red/vga_green/vga_blue  out  CW each  registered colour, 0 outside active video.
REQ-018 vga_sync  out  1  constant 0; vga_clk  out  1  equals clk.
Function
REQ-019 H_TOTAL SHALL be the sum of the four H lengths; V_TOTAL likewise.
REQ-020 h_cnt SHALL count 0..H_TOTAL-1 on each pix_en cycle, wrapping to 0; v_cnt SHALL increment only on h_cnt wrap, wrapping 0 after V_TOTAL-1.
REQ-021 Regions by count: active [0,ACTIVE), front [ACTIVE,ACTIVE+FRONT), pulse next PULSE counts, back the remainder; sync asserted only in the pulse region.
REQ-022 req_active, x=h_cnt, y=v_cnt, line_start, frame_start SHALL be combinational from counters, gated by pix_en for the pulses.
REQ-023 Sync/active flags SHALL pass through a LOOKAHEAD+1-stage enabled delay line so hsync, vsync, vga_blank reflect counter position LOOKAHEAD+1 enabled cycles earlier.
REQ-024 Colour outputs SHALL register red_in/green_in/blue_in on enabled cycles when the LOOKAHEAD-delayed active flag is 1, else register 0; colour and vga_blank thus align.
REQ-025 With pix_en=0 counters, delay line and all registered outputs SHALL hold; no pulse asserts.
REQ-026 Vertical region changes SHALL occur exactly at h_cnt wrap; hsync keeps running through vertical blanking.
REQ-027 x/y SHALL never exceed H_ACTIVE-1/V_ACTIVE-1.
Reset
REQ-028 On reset: h_cnt=v_cnt=0, delay line filled with blanking/sync-deasserted, hsync=!HS_POL, vsync=!VS_POL, vga_blank=0, colours 0.
REQ-029 Reset SHALL win over pix_en and apply mid-frame in the following cycle; first enabled cycle after release issues frame_start with x=y=0.
REQ-030 Outputs SHALL stay blanked for LOOKAHEAD+1 enabled cycles after reset regardless of inputs.
Verification (H 8/2/2/2, V 4/1/1/1, LOOKAHEAD=2, pix_en=1 unless stated)
REQ-031 Release reset -> frame_start at cycle 0, x=0..7 cycles 0..7, x=0/req_active=0 cycles 8..13, line_start every 14 cycles.
REQ-032 hsync (HS_POL=0) -> low exactly 2 cycles, first low at cycle 13 (count 10 + 3 delay), period 14.
REQ-033 red_in = 8'hA5 constant -> vga_red=A5 with vga_blank=1 at cycles 3..10 of each active line, 0 elsewhere; vsync low for 14 cycles starting line 5 + 3 cycles.
REQ-034 pix_en toggling 1/0 -> all outputs identical to REQ-031..033 sequence stretched 2x, no pulse on disabled cycles.
REQ-035 Reset asserted at line 2, x=5 -> next cycle all outputs at reset values; after release frame restarts at (0,0).
REQ-036 Default 640x480 parameters -> H_TOTAL=800, V_TOTAL=525, one frame_start per 420000 enabled cycles.
